// File: rtl/twiddle_rom_sched.sv
// Twiddle ROM address / butterfly index scheduler for a 256-point NTT.
// Issues two butterflies per cycle (8 layers x 64 cycles); outputs align with 1-cycle ROM data.
module twiddle_rom_sched #(
  parameter int ADDR_W = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              stall,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addra,
  output logic [ADDR_W-1:0] rom_addrb,
  output logic [COEF_W-1:0] idx0_a,
  output logic [COEF_W-1:0] idx0_b,
  output logic [COEF_W-1:0] idx1_a,
  output logic [COEF_W-1:0] idx1_b,
  output logic [2:0]        layer,
  output logic              neg,
  output logic              zeta_valid,
  output logic              busy,
  output logic              done,
  output logic              dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  logic [2:0]  r_l;
  logic [5:0]  r_c;
  logic        r_mode;

  logic        w_issue;
  logic        w_last;
  logic [47:0] w_calc0;
  logic [47:0] w_calc1;

  // Returns {rom_addr, j, j+len} (16 bits each) for butterfly b of layer l.
  function automatic logic [47:0] calc(input logic [6:0] b, input logic [2:0] l,
                                       input logic inv);
    logic [15:0] len;
    logic [15:0] grp;
    logic [15:0] addr;
    logic [15:0] j;
    len  = inv ? (16'd1 << l) : (16'd128 >> l);
    grp  = inv ? (16'(b) >> l) : (16'(b) >> (3'd7 - l));
    addr = inv ? ((16'd256 >> l) - 16'd1 - grp) : ((16'd1 << l) + grp);
    j    = ((len << 1) * grp) + (16'(b) & (len - 16'd1));
    return {addr, j, j + len};
  endfunction

  // start is a one-cycle request honoured only in IDLE (and not on the done cycle);
  // stall is a level hold: while high no issue happens and every counter freezes.
  assign w_issue   = (r_state == S_RUN) && !stall;
  assign w_last    = (r_l == 3'd7) && (r_c == 6'd63);
  assign dbg_state = r_state;

  always_comb begin
    w_calc0   = calc({r_c, 1'b0}, r_l, r_mode);
    w_calc1   = calc({r_c, 1'b1}, r_l, r_mode);
    rom_en    = w_issue;
    rom_addra = w_issue ? ADDR_W'(w_calc0[47:32]) : '0;
    rom_addrb = w_issue ? ADDR_W'(w_calc1[47:32]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_l        <= '0;
      r_c        <= '0;
      r_mode     <= 1'b0;
      idx0_a     <= '0;
      idx0_b     <= '0;
      idx1_a     <= '0;
      idx1_b     <= '0;
      layer      <= '0;
      neg        <= 1'b0;
      zeta_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      zeta_valid <= w_issue;
      done       <= w_issue && w_last;
      if (w_issue) begin
        idx0_a <= COEF_W'(w_calc0[31:16]);
        idx0_b <= COEF_W'(w_calc0[15:0]);
        idx1_a <= COEF_W'(w_calc1[31:16]);
        idx1_b <= COEF_W'(w_calc1[15:0]);
        layer  <= r_l;
        neg    <= r_mode;
      end
      case (r_state)
        S_IDLE: begin
          // done high here means this is the completion cycle: a start now is dropped.
          if (start && !done) begin
            r_state <= S_RUN;
            r_mode  <= mode;
            r_l     <= '0;
            r_c     <= '0;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            r_c <= r_c + 6'd1;
            if (r_c == 6'd63) r_l <= r_l + 3'd1;
            if (w_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/twiddle_rom_sched.md
TWIDDLE_ROM_SCHED -- requirements
Module: twiddle_rom_sched

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_W, default 8, meaning twiddle ROM address width (256 entries).
REQ-002 SHALL have parameter COEF_W, default 8, meaning coefficient index width (256 coefficients).
Ports:
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transform.
REQ-006 SHALL have port mode  input  1  0 = forward NTT, 1 = inverse NTT; sampled with start.
REQ-007 SHALL have port stall  input  1  downstream hold; freezes issue while high.
REQ-008 SHALL have port rom_en  output  1  enable to dual-port twiddle ROM.
REQ-009 SHALL have ports rom_addra, rom_addrb  output  ADDR_W each  ROM read addresses, butterfly unit 0 and unit 1.
REQ-010 SHALL have ports idx0_a, idx0_b, idx1_a, idx1_b  output  COEF_W each  coefficient pair indices (j, j+len) for unit 0 and unit 1, aligned with ROM data.
REQ-011 SHALL have port layer  output  3  layer of the aligned data.
REQ-012 SHALL have port neg  output  1  aligned data uses negated zeta (inverse mode).
REQ-013 SHALL have port zeta_valid  output  1  ROM data and aligned outputs are valid this cycle.
REQ-014 SHALL have ports busy, done  output  1 each  transform in progress; one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE and RUN; IDLE -> RUN on start=1; RUN -> IDLE after the final issue.
REQ-016 SHALL ignore start while in RUN; mode is latched only on an accepted start.
REQ-017 SHALL keep a 3-bit layer counter l (0..7) and a 6-bit cycle counter c (0..63) per layer; butterflies b0 = 2c, b1 = 2c+1.
REQ-018 SHALL define issue = RUN & ~stall; drive rom_en = issue combinationally; on issue, advance c, wrap 63 -> 0, and increment l on wrap.
REQ-019 SHALL compute for forward mode: len = 128 >> l, group g = b >> (7-l), ROM address = (1 << l) + g.
REQ-020 SHALL compute for inverse mode: len = 1 << l, g = b >> l, ROM address = (256 >> l) - 1 - g.
REQ-021 SHALL compute the coefficient indices as j = 2*len*g + (b mod len) and partner j + len, all modulo 2^COEF_W.
REQ-022 SHALL register idx*, layer and neg on issue; these registers hold when not issuing.
REQ-023 SHALL register zeta_valid <= issue, giving ROM latency 1 and aligning zeta_valid with ROM data.
REQ-024 SHALL make 512 issues per transform; with no stall, start sampled at edge E0 -> issues at E1..E512 -> zeta_valid high after E1..E512.
REQ-025 SHALL hold busy high from the edge accepting start through the cycle done is high.
REQ-026 SHALL pulse done for exactly one cycle, coincident with the final zeta_valid.
REQ-027 SHALL, on stall=1, hold all counters, keep rom_en=0 (ROM output holds), and drive zeta_valid=0 next cycle.
REQ-028 SHALL resume on stall deassertion with no issue lost or duplicated.
REQ-029 SHALL apply the same rules to stall in the final cycle: done waits for the final issue.
REQ-030 SHALL, when start arrives the same cycle as done, ignore it.

Reset
REQ-031 SHALL, on rst_n=0 (asynchronous, any state including mid-RUN), force IDLE, l=0, c=0, latched mode=0, and set all outputs to 0.
REQ-032 SHALL resume operation on the first rising clk edge after rst_n deasserts; no partial transform continues.

Verification
REQ-033 SHALL cover forward, no stall: first valid -> addra=1, addrb=1, idx0=(0,128), idx1=(1,129), layer=0, neg=0; last valid -> addra=254, addrb=255, idx0=(252,253), idx1=(254,255), layer=7, done high same cycle.
REQ-034 SHALL cover inverse, no stall: first valid -> addra=255, addrb=254, idx0=(0,1), idx1=(2,3), neg=1; layer-7 valids -> addr=1 both, idx0=(2c,2c+128).
REQ-035 SHALL cover timing: start at E0 with no stall -> zeta_valid count = 512 and done high after E512, exactly once.
REQ-036 SHALL cover stall: 5-cycle stall at c=63 of layer 2 -> no layer advance, zeta_valid low, no lost or duplicate address pairs, done delayed by 5 cycles.
REQ-037 SHALL cover start during RUN and on the done cycle -> ignored; busy falls after done; a later start is accepted.
REQ-038 SHALL cover reset: rst_n low mid-layer 4 -> all outputs 0 immediately; a new start after release gives the first-valid values of REQ-033.
